// File: rtl/cntlr_uart_tx.sv
// 8N1 UART framer for JOYBUS controller words: sync byte + 4 data bytes, MSB first.
// Define CNTLR_UART_CHKSUM_EN to append an XOR checksum byte to every frame.
module cntlr_uart_tx #(
  parameter int          BAUD_DIV  = 217,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cntlr_data_rdy,
  input  logic [31:0] cntlr_data,
  output logic        TX,
  output logic        tx_busy,
  output logic        pend_valid,
  output logic [7:0]  drop_cnt
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

`ifdef CNTLR_UART_CHKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    r_byte_idx;
  logic [31:0]   r_frame_word;
  logic [31:0]   r_pend_word;
  logic          r_pend_valid;
  logic [7:0]    r_drop_cnt;

  logic          w_idle;
  logic          w_baud_done;
  logic          w_final;
  logic          w_start;
  logic [7:0]    w_cur_byte;

  assign w_idle      = (r_state == S_IDLE);
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_final     = (r_state == S_STOP) && w_baud_done &&
                       (r_byte_idx == LAST_BYTE);
  assign w_start     = cntlr_data_rdy || r_pend_valid;

  assign tx_busy    = !w_idle;
  assign pend_valid = r_pend_valid;
  assign drop_cnt   = r_drop_cnt;

`ifdef CNTLR_UART_CHKSUM_EN
  logic [7:0] w_chk;
  assign w_chk = r_frame_word[31:24] ^ r_frame_word[23:16] ^
                 r_frame_word[15:8]  ^ r_frame_word[7:0];
`endif

  always_comb begin
    w_cur_byte = SYNC_BYTE;
    case (r_byte_idx)
      3'd1: w_cur_byte = r_frame_word[31:24];
      3'd2: w_cur_byte = r_frame_word[23:16];
      3'd3: w_cur_byte = r_frame_word[15:8];
      3'd4: w_cur_byte = r_frame_word[7:0];
`ifdef CNTLR_UART_CHKSUM_EN
      3'd5: w_cur_byte = w_chk;
`endif
      default: w_cur_byte = SYNC_BYTE;
    endcase
  end

  // TX is decoded from reset-cleared state so a reset forces idle-high at once
  always_comb begin
    TX = 1'b1;
    case (r_state)
      S_START: TX = 1'b0;
      S_DATA:  TX = w_cur_byte[r_bit_idx];
      default: TX = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_START;
            r_byte_idx <= '0;
            r_baud_cnt <= '0;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7)
              r_state <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        default: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_byte_idx != LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_state    <= S_START;
            end else if (w_start) begin
              r_byte_idx <= '0;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // On the final stop edge a new word chains in without counting as a drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_word <= '0;
      r_pend_word  <= '0;
      r_pend_valid <= 1'b0;
      r_drop_cnt   <= '0;
    end else if (w_idle) begin
      if (cntlr_data_rdy) begin
        r_frame_word <= cntlr_data;
      end else if (r_pend_valid) begin
        r_frame_word <= r_pend_word;
        r_pend_valid <= 1'b0;
      end
    end else if (w_final) begin
      if (r_pend_valid) begin
        r_frame_word <= r_pend_word;
        if (cntlr_data_rdy)
          r_pend_word <= cntlr_data;
        else
          r_pend_valid <= 1'b0;
      end else if (cntlr_data_rdy) begin
        r_frame_word <= cntlr_data;
      end
    end else if (cntlr_data_rdy) begin
      r_pend_word  <= cntlr_data;
      r_pend_valid <= 1'b1;
      if (r_pend_valid && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule
